// File: rtl/ram_sweep.sv
// ram_sweep: single-port-per-direction word RAM with byte-lane writes,
// a registered read port with write-first forwarding, and a hardware
// clear sweep that zeroes every word after reset or on request.
module ram_sweep #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int BYTE_W = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr_req,
    output logic                     busy,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/BYTE_W-1:0] wbe,
    input  logic                     ren,
    input  logic [ADDR_W-1:0]        raddr,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   count, count_next;
    logic                sweep_we;
    logic                wr_acc;
    logic                rd_acc;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   mem [DEPTH];

    // State register and sweep counter; reset restarts a full sweep from 0.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= SWEEP;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state logic, sweep progress and user-access acceptance.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        count_next = count;
        busy       = 1'b0;
        sweep_we   = 1'b0;
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        case (state)
            SWEEP: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                if (clr_req) begin
                    count_next = '0;
                end else begin
                    count_next = count + ADDR_W'(1);
                    if (count == CNT_LAST) begin
                        state_next = IDLE;
                    end
                end
            end
            IDLE: begin
                if (clr_req) begin
                    // Requests arriving with the clear are dropped.
                    state_next = SWEEP;
                    count_next = '0;
                end else begin
                    wr_acc = wen;
                    rd_acc = ren;
                end
            end
            default: state_next = SWEEP;
        endcase
    end

    // Read word with same-cycle write forwarded per byte lane (write-first).
    always_comb begin
        rd_word = mem[raddr];
        for (int i = 0; i < NB; i++) begin
            if (wr_acc && wbe[i] && (waddr == raddr)) begin
                rd_word[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Memory array: sweep zeroing has priority, otherwise byte-lane writes.
    // NOTE: the array has no reset; contents are cleared by the sweep, which
    // keeps it mappable onto RAM macros that cannot be reset.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[count] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Registered read port; rdata holds until the next accepted read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) begin
                rdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_ram_sweep.sv
// Testbench for ram_sweep (ADDR_W=4, DATA_W=16, BYTE_W=8): directed
// scenarios with literal expectations plus randomized traffic checked
// every cycle against a behavioural model of the memory.
module tb_ram_sweep;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int BW    = 8;
    localparam int NB    = DW / BW;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr_req = 1'b0;
    logic          busy;
    logic          wen = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [NB-1:0] wbe = '0;
    logic          ren = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] rdata;
    logic          rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    ram_sweep #(.ADDR_W(AW), .DATA_W(DW), .BYTE_W(BW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .clr_req (clr_req),
        .busy    (busy),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .wbe     (wbe),
        .ren     (ren),
        .raddr   (raddr),
        .rdata   (rdata),
        .rvalid  (rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The memory is a plain array; a sweep is a count of remaining busy
    // cycles, and since nothing can be read until it ends, the model just
    // zeroes the whole array when a sweep begins.
    logic [DW-1:0] m_mem [DEPTH];
    int            sweep_left = DEPTH;
    logic          exp_rvalid = 1'b0;
    logic [DW-1:0] exp_rdata  = '0;
    logic          model_live = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sweep_left = DEPTH;
            exp_rvalid = 1'b0;
            exp_rdata  = '0;
            model_live = 1'b1;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (sweep_left > 0) begin
            exp_rvalid = 1'b0;
            sweep_left = clr_req ? DEPTH : sweep_left - 1;
        end else if (clr_req) begin
            exp_rvalid = 1'b0;
            sweep_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            if (wen) begin
                for (int b = 0; b < NB; b++)
                    if (wbe[b]) m_mem[waddr][b*BW +: BW] = wdata[b*BW +: BW];
            end
            exp_rvalid = ren;
            if (ren) exp_rdata = m_mem[raddr];
        end
    end

    // Compare process: outputs against the model, every cycle.
    always @(negedge clk) begin
        if (model_live) begin
            check("busy",   busy,   (sweep_left > 0));
            check("rvalid", rvalid, exp_rvalid);
            check("rdata",  rdata,  exp_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NB-1:0] be, input logic r, input logic [AW-1:0] ra,
                         input logic c);
        @(negedge clk);
        wen = w; waddr = wa; wdata = wd; wbe = be; ren = r; raddr = ra; clr_req = c;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        drive(1'b1, a, d, be, 1'b0, '0, 1'b0);
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        drive(1'b0, '0, '0, '0, 1'b1, a, 1'b0);
        @(posedge clk); #1;
        check({name, "_rvalid"}, rvalid, 1'b1);
        check({name, "_rdata"}, rdata, exp);
    endtask

    // Counts cycles busy stays high, sampled just after each edge.
    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int n;

    initial begin
        // Reset and initial sweep.
        #2;
        check("reset_busy",   busy,   1'b1);
        check("reset_rvalid", rvalid, 1'b0);
        check("reset_rdata",  rdata,  16'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        busy_len(n);
        check("init_sweep_len", n, DEPTH);

        // Every word reads zero after the sweep, back to back.
        for (int a = 0; a < DEPTH; a++) read_check("init_zero", a[AW-1:0], 16'h0000);
        idle();

        // Byte-lane merge.
        write(4'd3, 16'hABCD, 2'b11);
        write(4'd3, 16'h12FF, 2'b01);
        write(4'd3, 16'h7777, 2'b00);
        read_check("lane_merge", 4'd3, 16'hABFF);

        // Same-cycle write and read: write-first.
        drive(1'b1, 4'd5, 16'h1234, 2'b11, 1'b1, 4'd5, 1'b0);
        @(posedge clk); #1;
        check("wfirst_rvalid", rvalid, 1'b1);
        check("wfirst_rdata",  rdata,  16'h1234);

        // Back-to-back reads then rvalid drops, rdata holds.
        write(4'd0, 16'h000A, 2'b11);
        write(4'd1, 16'h000B, 2'b11);
        write(4'd2, 16'h000C, 2'b11);
        read_check("b2b0", 4'd0, 16'h000A);
        read_check("b2b1", 4'd1, 16'h000B);
        read_check("b2b2", 4'd2, 16'h000C);
        idle();
        @(posedge clk); #1;
        check("b2b_end_rvalid", rvalid, 1'b0);
        check("b2b_hold_rdata", rdata,  16'h000C);

        // Reset at sweep counter 9.
        drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_busy",   busy,   1'b1);
        check("midrst_rvalid", rvalid, 1'b0);
        check("midrst_rdata",  rdata,  16'h0);
        @(negedge clk);
        rstn = 1'b1;
        busy_len(n);
        check("midrst_sweep_len", n, DEPTH);

        // Clear restart mid-sweep; accesses during the sweep are dropped.
        write(4'd7, 16'h5555, 2'b11);
        read_check("pre_clr", 4'd7, 16'h5555);
        drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        wen = 1'b1; waddr = 4'd7; wdata = 16'hFFFF; wbe = 2'b11;
        ren = 1'b1; raddr = 4'd7;
        busy_len(n);
        wen = 1'b0; ren = 1'b0;
        check("restart_sweep_len", n, DEPTH);
        read_check("post_clr", 4'd7, 16'h0000);
        idle();

        // Randomized traffic, checked by the compare process.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            wen     = $urandom_range(0, 1);
            waddr   = AW'($urandom_range(0, DEPTH - 1));
            wdata   = DW'($urandom);
            wbe     = NB'($urandom_range(0, 3));
            ren     = $urandom_range(0, 1);
            raddr   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
            clr_req = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 499) == 0) begin
                #2 rstn = 1'b0;
                @(negedge clk);
                rstn = 1'b1;
            end
        end
        idle();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sweep.md
RAM_SWEEP -- requirements
Module: ram_sweep

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width; depth = 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 16, word width.
REQ-003 SHALL have parameter BYTE_W, default 8, byte-lane width; DATA_W is an integer multiple of BYTE_W; NB = DATA_W/BYTE_W.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr_req  in  1  request a full-memory clear sweep.
REQ-007 SHALL have port busy  out  1  sweep in progress; user accesses ignored.
REQ-008 SHALL have port wen  in  1  write enable.
REQ-009 SHALL have port waddr  in  ADDR_W  write word address.
REQ-010 SHALL have port wdata  in  DATA_W  write data.
REQ-011 SHALL have port wbe  in  NB  byte-lane write enables; bit i covers wdata[i*BYTE_W +: BYTE_W].
REQ-012 SHALL have port ren  in  1  read request.
REQ-013 SHALL have port raddr  in  ADDR_W  read word address.
REQ-014 SHALL have port rdata  out  DATA_W  registered read data.
REQ-015 SHALL have port rvalid  out  1  one-cycle pulse marking new rdata.

Function
REQ-016 SHALL implement a two-state FSM, SWEEP and IDLE, plus an ADDR_W-bit sweep counter.
REQ-017 In SWEEP, each cycle SHALL write all-zero to mem[counter] and increment the counter; at counter = 2**ADDR_W-1 it SHALL write that word and go to IDLE next cycle; a sweep therefore takes exactly 2**ADDR_W cycles.
REQ-018 busy SHALL be 1 exactly when state = SWEEP.
REQ-019 In SWEEP, wen and ren SHALL be ignored: no user write, rvalid stays 0, rdata holds its value.
REQ-020 clr_req sampled high in IDLE SHALL move to SWEEP with counter = 0 on the next cycle; a wen or ren in that same cycle SHALL be dropped.
REQ-021 clr_req sampled high in SWEEP SHALL restart the counter at 0; the sweep then runs a full 2**ADDR_W more cycles.
REQ-022 In IDLE, wen=1 SHALL update only the byte lanes of mem[waddr] whose wbe bit is 1; other lanes unchanged; wen=1 with wbe=0 is a no-op.
REQ-023 In IDLE, ren=1 in cycle N SHALL drive rdata = mem[raddr] and rvalid = 1 in cycle N+1 (latency 1); rvalid SHALL be 0 in any cycle with no accepted read in the previous cycle.
REQ-024 rdata SHALL hold its last value until the next accepted read.
REQ-025 On read and write to the same address in the same cycle, the read SHALL return the post-write word (write-first, per byte lane).
REQ-026 Back-to-back reads SHALL be accepted every cycle; rvalid stays 1 across them.
REQ-027 No backpressure SHALL exist; every request in IDLE is accepted.

Reset
REQ-028 rstn low SHALL asynchronously force state = SWEEP, counter = 0, busy = 1, rvalid = 0, rdata = 0.
REQ-029 Memory contents SHALL NOT be reset asynchronously; they are cleared only by the sweep that starts after rstn rises.
REQ-030 rstn asserted mid-sweep or mid-operation SHALL abandon all progress; after release a full sweep from address 0 runs.

Verification (ADDR_W=4, DATA_W=16, BYTE_W=8)
REQ-031 Release rstn -> busy=1 for exactly 16 cycles then 0; ren at raddr 0..15 -> rdata=0x0000 with rvalid each following cycle.
REQ-032 In IDLE, write 0xABCD wbe=11 to addr 3, then 0x12FF wbe=01 to addr 3, then ren addr 3 -> rdata=0xABFF.
REQ-033 Same cycle wen addr 5 data 0x1234 wbe=11 and ren addr 5, old value 0x0000 -> next cycle rdata=0x1234, rvalid=1.
REQ-034 Write 0x5555 to addr 7, pulse clr_req, 8 cycles later pulse clr_req again -> busy stays 1 for 16 cycles after the second pulse; wen/ren issued while busy are ignored (rvalid=0); afterwards addr 7 reads 0x0000.
REQ-035 Assert rstn low at sweep counter 9 -> busy=1, rvalid=0, rdata=0 immediately; after release busy=1 for 16 full cycles.
REQ-036 ren every cycle on addrs 0,1,2 holding 0x0A,0x0B,0x0C -> rvalid=1 for 3 consecutive cycles with rdata 0x000A,0x000B,0x000C, then rvalid=0.
